// File: rtl/mem_arb_defs.sv
// rtl/mem_arb_defs.sv - shared FSM encodings, port IDs and latency default for mem_arb
package mem_arb_defs;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2
  } state_t;

  // Requester identities, also used for the last-grant record
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_id_t;

  // Default unified-memory read latency in cycles (legal 1..15)
  localparam int MEM_LAT_DEFAULT = 2;

  // Width of the in-grant cycle counter; must hold the largest legal latency
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection for mem_arb (round-robin ties with MEM_ARB_RR_EN)
module arb_pick
  import mem_arb_defs::*;
(
  input  logic     req_if,
  input  logic     req_dm,
`ifdef MEM_ARB_RR_EN
  input  port_id_t last_grant,
`endif
  output port_id_t winner
);

  // A lone requester wins; a tie goes to dm, or to the port not served last when round-robin is on
  always_comb begin
    winner = PORT_DM;
    if (req_if && !req_dm) begin
      winner = PORT_IF;
    end
`ifdef MEM_ARB_RR_EN
    else if (req_if && req_dm) begin
      winner = (last_grant == PORT_DM) ? PORT_IF : PORT_DM;
    end
`endif
  end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - fetch/data arbiter onto a single unified memory; define MEM_ARB_RR_EN for round-robin ties
module mem_arb
  import mem_arb_defs::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               lat_we;
  logic               elig_if;
  logic               elig_dm;
  port_id_t           winner;
`ifdef MEM_ARB_RR_EN
  port_id_t           last_grant;
`endif

  // A port still showing its done pulse may not win again in that same cycle
  assign elig_if = if_req & ~if_done;
  assign elig_dm = dm_req & ~dm_done;

  // Stalls are held low during reset so that every output reads zero while rst_n is low
  assign stall_if  = rst_n & if_req & ~if_done;
  assign stall_mem = rst_n & dm_req & ~dm_done;

  arb_pick u_pick (
    .req_if     (elig_if),
    .req_dm     (elig_dm),
`ifdef MEM_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .winner     (winner)
  );

  // Grant FSM: latch the winner's transaction, strobe the command once, wait MEM_LAT, then complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant <= PORT_IF;
`endif
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (elig_if || elig_dm) begin
            cnt <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant <= winner;
`endif
            if (winner == PORT_DM) begin
              state     <= GNT_DM;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              lat_we    <= dm_we;
              mem_we    <= dm_we;
              mem_re    <= ~dm_we;
            end else begin
              state     <= GNT_IF;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              lat_we    <= 1'b0;
              mem_re    <= 1'b1;
            end
          end
        end
        GNT_IF, GNT_DM: begin
          if (cnt == LAT) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (state == GNT_IF) begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end else begin
              if (!lat_we) begin
                dm_rdata <= mem_rdata;
              end
              dm_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb at MEM_LAT 2, 1 and 15
module tb_mem_arb;

  localparam int NI = 3;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  // Memory contents: a fixed function of the address
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'hA5B5;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr, dm_wdata;

  logic [15:0] if_rdata_v [NI];
  logic [15:0] dm_rdata_v [NI];
  logic [15:0] mem_addr_v [NI];
  logic [15:0] mem_wdata_v[NI];
  logic [15:0] mem_rdata_v[NI];
  logic        if_done_v  [NI];
  logic        dm_done_v  [NI];
  logic        mem_re_v   [NI];
  logic        mem_we_v   [NI];
  logic        stall_if_v [NI];
  logic        stall_mem_v[NI];

  int checks   = 0;
  int failures = 0;
  int tc       = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_arb #(.MEM_LAT(lat_of(g))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata_v[g]),
      .if_done   (if_done_v[g]),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata_v[g]),
      .dm_done   (dm_done_v[g]),
      .mem_addr  (mem_addr_v[g]),
      .mem_re    (mem_re_v[g]),
      .mem_we    (mem_we_v[g]),
      .mem_wdata (mem_wdata_v[g]),
      .mem_rdata (mem_rdata_v[g]),
      .stall_if  (stall_if_v[g]),
      .stall_mem (stall_mem_v[g])
    );
  end

  // Memory environment: data is valid only in the cycle exactly MEM_LAT after mem_re
  logic [15:0] re_hist[NI];
  logic [15:0] a_hist [NI][16];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      re_hist[k] <= {re_hist[k][14:0], mem_re_v[k]};
      for (int j = 15; j > 0; j--) a_hist[k][j] <= a_hist[k][j-1];
      a_hist[k][0] <= mem_addr_v[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      mem_rdata_v[k] = re_hist[k][lat_of(k)-1] ? mem_fn(a_hist[k][lat_of(k)-1]) : 16'hDEAD;
    end
  end

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%h expected=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding transaction per instance, timed by its age in cycles
  bit          busy   [NI];
  int          age    [NI];
  bit          gdm    [NI];
  bit          gwe    [NI];
  logic [15:0] gaddr  [NI];
  logic [15:0] gwdata [NI];
  bit          pend_if[NI];
  bit          pend_dm[NI];
  bit          last_dm[NI];
  logic [15:0] e_ifr  [NI];
  logic [15:0] e_dmr  [NI];

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        bit n_if, n_dm, eif, edm, tie_dm, take_dm;
        if (!rst_n) begin
          busy[k] = 0; age[k] = 0; gdm[k] = 0; gwe[k] = 0;
          gaddr[k] = '0; gwdata[k] = '0;
          pend_if[k] = 0; pend_dm[k] = 0; last_dm[k] = 0;
          e_ifr[k] = '0; e_dmr[k] = '0;
        end
        chk("mem_re",    k, 16'(mem_re_v[k]),    16'(busy[k] && age[k] == 0 && !gwe[k]));
        chk("mem_we",    k, 16'(mem_we_v[k]),    16'(busy[k] && age[k] == 0 && gwe[k]));
        chk("mem_addr",  k, mem_addr_v[k],       busy[k] ? gaddr[k] : 16'h0000);
        chk("mem_wdata", k, mem_wdata_v[k],      busy[k] ? gwdata[k] : 16'h0000);
        chk("if_done",   k, 16'(if_done_v[k]),   16'(pend_if[k]));
        chk("dm_done",   k, 16'(dm_done_v[k]),   16'(pend_dm[k]));
        chk("if_rdata",  k, if_rdata_v[k],       e_ifr[k]);
        chk("dm_rdata",  k, dm_rdata_v[k],       e_dmr[k]);
        chk("stall_if",  k, 16'(stall_if_v[k]),  16'(rst_n && if_req && !pend_if[k]));
        chk("stall_mem", k, 16'(stall_mem_v[k]), 16'(rst_n && dm_req && !pend_dm[k]));
        if (rst_n) begin
          n_if = 0;
          n_dm = 0;
          if (busy[k]) begin
            if (age[k] == lat_of(k)) begin
              busy[k] = 0;
              if (!gdm[k]) begin
                e_ifr[k] = mem_fn(gaddr[k]);
                n_if = 1;
              end else begin
                if (!gwe[k]) e_dmr[k] = mem_fn(gaddr[k]);
                n_dm = 1;
              end
            end else begin
              age[k]++;
            end
          end else begin
            eif = if_req && !pend_if[k];
            edm = dm_req && !pend_dm[k];
`ifdef MEM_ARB_RR_EN
            tie_dm = !last_dm[k];
`else
            tie_dm = 1;
`endif
            if (eif || edm) begin
              take_dm    = edm && (!eif || tie_dm);
              busy[k]    = 1;
              age[k]     = 0;
              gdm[k]     = take_dm;
              last_dm[k] = take_dm;
              gaddr[k]   = take_dm ? dm_addr : if_addr;
              gwe[k]     = take_dm && dm_we;
              gwdata[k]  = take_dm ? dm_wdata : 16'h0000;
            end
          end
          pend_if[k] = n_if;
          pend_dm[k] = n_dm;
        end
      end
    end
  end

  // Test-relative cycle control: cycle 0 is the cycle the stimulus is first applied
  task automatic start_test();
    @(posedge clk);
    #1;
    tc = 0;
  endtask

  task automatic go(input int n);
    while (tc < n) begin
      @(posedge clk);
      #1;
      tc++;
    end
  endtask

  task automatic smp(input int n);
    go(n);
    @(negedge clk);
  endtask

  task automatic idle_gap();
    if_req = 0;
    dm_req = 0;
    dm_we  = 0;
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_mem_addr", k, mem_addr_v[k], 16'h0000);
      chk("rst_if_done",  k, 16'(if_done_v[k]), 16'h0000);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;

    // Lone fetch; address change and request drop mid-grant are ignored
    start_test();
    if_req = 1; if_addr = 16'h0010;
    smp(1);
    chk("t1_mem_re",   0, 16'(mem_re_v[0]), 16'h0001);
    chk("t1_mem_addr", 0, mem_addr_v[0], 16'h0010);
    go(2);
    if_req = 0; if_addr = 16'hBEEF;
    smp(2);
    chk("t1_mem_re_c2",   0, 16'(mem_re_v[0]), 16'h0000);
    chk("t1_mem_addr_c2", 0, mem_addr_v[0], 16'h0010);
    smp(3);
    chk("t1_lat1_done", 1, 16'(if_done_v[1]), 16'h0001);
    chk("t1_done_c3",   0, 16'(if_done_v[0]), 16'h0000);
    smp(4);
    chk("t1_if_done",  0, 16'(if_done_v[0]), 16'h0001);
    chk("t1_if_rdata", 0, if_rdata_v[0], 16'hA5A5);
    smp(16);
    chk("t1_lat15_c16", 2, 16'(if_done_v[2]), 16'h0000);
    smp(17);
    chk("t1_lat15_done", 2, 16'(if_done_v[2]), 16'h0001);
    idle_gap();

    // Simultaneous fetch and data read: dm first, fetch follows
    start_test();
    if_req = 1; if_addr = 16'h0100;
    dm_req = 1; dm_we = 0; dm_addr = 16'h0040;
    smp(0);
    chk("t2_stall_if_c0", 0, 16'(stall_if_v[0]), 16'h0001);
    smp(1);
    chk("t2_dm_first", 0, mem_addr_v[0], 16'h0040);
    smp(4);
    chk("t2_dm_done",   0, 16'(dm_done_v[0]), 16'h0001);
    chk("t2_dm_rdata",  0, dm_rdata_v[0], 16'hA5F5);
    chk("t2_stall_if4", 0, 16'(stall_if_v[0]), 16'h0001);
    go(5);
    dm_req = 0;
    smp(5);
    chk("t2_if_addr", 0, mem_addr_v[0], 16'h0100);
    smp(7);
    chk("t2_stall_if7", 0, 16'(stall_if_v[0]), 16'h0001);
    smp(8);
    chk("t2_if_done",   0, 16'(if_done_v[0]), 16'h0001);
    chk("t2_if_rdata",  0, if_rdata_v[0], 16'hA4B5);
    chk("t2_stall_if8", 0, 16'(stall_if_v[0]), 16'h0000);
    idle_gap();

    // Data write leaves dm_rdata untouched
    start_test();
    dm_req = 1; dm_we = 1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
    smp(1);
    chk("t3_mem_we",    0, 16'(mem_we_v[0]), 16'h0001);
    chk("t3_mem_re",    0, 16'(mem_re_v[0]), 16'h0000);
    chk("t3_mem_wdata", 0, mem_wdata_v[0], 16'h1234);
    go(2);
    dm_req = 0;
    smp(2);
    chk("t3_mem_we_c2", 0, 16'(mem_we_v[0]), 16'h0000);
    smp(4);
    chk("t3_dm_done",  0, 16'(dm_done_v[0]), 16'h0001);
    chk("t3_dm_rdata", 0, dm_rdata_v[0], 16'hA5F5);
    idle_gap();

    // Reset in the middle of a fetch aborts it; a held request restarts afterwards
    start_test();
    if_req = 1; if_addr = 16'h0030;
    smp(1);
    chk("t4_mem_re", 0, 16'(mem_re_v[0]), 16'h0001);
    go(2);
    rst_n = 0;
    smp(2);
    chk("t4_rst_addr",   0, mem_addr_v[0], 16'h0000);
    chk("t4_rst_ifr",    0, if_rdata_v[0], 16'h0000);
    chk("t4_rst_dmr",    0, dm_rdata_v[0], 16'h0000);
    chk("t4_rst_stall",  0, 16'(stall_if_v[0]), 16'h0000);
    go(4);
    rst_n = 1;
    smp(4);
    chk("t4_no_done", 0, 16'(if_done_v[0]), 16'h0000);
    smp(5);
    chk("t4_restart_re",   0, 16'(mem_re_v[0]), 16'h0001);
    chk("t4_restart_addr", 0, mem_addr_v[0], 16'h0030);
    go(6);
    if_req = 0;
    smp(7);
    chk("t4_done_c7", 0, 16'(if_done_v[0]), 16'h0000);
    smp(8);
    chk("t4_if_done",  0, 16'(if_done_v[0]), 16'h0001);
    chk("t4_if_rdata", 0, if_rdata_v[0], 16'hA585);
    idle_gap();

    // Both requests held continuously: grants alternate DM, IF, DM, IF
    start_test();
    if_req = 1; if_addr = 16'h0200;
    dm_req = 1; dm_we = 0; dm_addr = 16'h0300;
    smp(1);
    chk("t5_grant1", 0, mem_addr_v[0], 16'h0300);
    smp(5);
    chk("t5_grant2", 0, mem_addr_v[0], 16'h0200);
    smp(9);
    chk("t5_grant3", 0, mem_addr_v[0], 16'h0300);
    smp(13);
    chk("t5_grant4", 0, mem_addr_v[0], 16'h0200);
    idle_gap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter MEM_LAT, default 2, sets the unified-memory read latency in cycles (legal 1..15).
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 if_req  input  1  instruction-fetch read request (level).
REQ-005 if_addr  input  16  fetch address (pc).
REQ-006 if_rdata  output  16  fetched instruction word.
REQ-007 if_done  output  1  one-cycle fetch completion pulse.
REQ-008 dm_req  input  1  data-stage request (level).
REQ-009 dm_we  input  1  1 = write, 0 = read.
REQ-010 dm_addr  input  16  data address (ALU result).
REQ-011 dm_wdata  input  16  store data.
REQ-012 dm_rdata  output  16  load data.
REQ-013 dm_done  output  1  one-cycle data completion pulse.
REQ-014 mem_addr  output  16  unified memory address.
REQ-015 mem_re / mem_we  output  1 each  memory read and write strobes.
REQ-016 mem_wdata  output  16  memory write data.
REQ-017 mem_rdata  input  16  memory read data, valid MEM_LAT cycles after the mem_re cycle.
REQ-018 stall_if / stall_mem  output  1 each  pipeline stall to fetch and memory stages.

Function
REQ-019 FSM states SHALL be IDLE, GNT_IF and GNT_DM; a 4-bit counter cnt SHALL run 0..MEM_LAT inside a grant state.
REQ-020 IDLE with any eligible request SHALL move to the winner's grant state at the next edge, latching address, we and wdata; cnt SHALL be cleared to 0.
REQ-021 Commands: mem_re or mem_we SHALL be high only in the cnt==0 cycle; mem_addr/mem_wdata SHALL drive the latched values for the whole grant and be 0 in IDLE.
REQ-022 At cnt==MEM_LAT the FSM SHALL capture mem_rdata into the granted port's rdata register (reads only), return to IDLE, and pulse that port's done for exactly the following cycle.
REQ-023 Latency: request sampled in cycle 0 -> command in cycle 1 -> done in cycle MEM_LAT+2.
REQ-024 if_rdata/dm_rdata SHALL hold their value until the next read completion on that port; writes SHALL leave dm_rdata unchanged.
REQ-025 A port whose done is high SHALL be ineligible for arbitration in that cycle.
REQ-026 Requests dropped or addresses changed mid-grant SHALL be ignored; the latched transaction completes and done still pulses.
REQ-027 Fixed priority: on simultaneous eligible requests dm wins.
REQ-028 stall_if = if_req & ~if_done and stall_mem = dm_req & ~dm_done, combinational.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, cnt=0, last_grant=IF, and every output low/zero, aborting any in-flight transaction with no done pulse.
REQ-030 The first arbitration after reset release SHALL occur at the first rising edge with rst_n high.

Configuration
REQ-031 With MEM_ARB_RR_EN defined, ties SHALL go to the port not granted last (last_grant register updated on each grant, reset to IF so the first tie goes to dm).
REQ-032 Without MEM_ARB_RR_EN, last_grant SHALL not exist and REQ-027 fixed priority applies.

Structure
REQ-033 FSM state encodings, port IDs (IF=0, DM=1) and the MEM_LAT default SHALL live in a shared header/package mem_arb_defs.
REQ-034 One combinational sub-module arb_pick (inputs: eligible requests, last_grant; output: winner) SHALL implement the priority choice.

Verification (MEM_LAT=2)
REQ-035 if_req alone, if_addr=0x0010, mem_rdata=0xA5A5 -> mem_re=1 with mem_addr=0x0010 in cycle 1, if_done in cycle 4, if_rdata=0xA5A5.
REQ-036 if_req and dm_req (read, 0x0040) both held from cycle 0, fixed priority -> dm_done in cycle 4, GNT_IF cycles 5-7, if_done in cycle 8; stall_if high cycles 0-7.
REQ-037 dm write addr=0x0020, wdata=0x1234 -> mem_we=1 for cycle 1 only, mem_wdata=0x1234, dm_done in cycle 4, dm_rdata unchanged.
REQ-038 MEM_ARB_RR_EN, both requests held continuously -> grant order DM, IF, DM, IF; no port granted twice in a row.
REQ-039 rst_n pulled low in cycle 2 of a fetch -> all outputs 0 immediately, no if_done; after release a held if_req restarts with the full latency.
REQ-040 MEM_LAT=1 and MEM_LAT=15 -> done in cycle 3 and cycle 17 respectively.
